setup_move_sequencer: RTL and testbench

Responder side of the state-scan handshake. determine_state pulses send_setup_moves with counter = number of stickers observed so far. This block expands that index into the required face-turn sequence and issues the moves one at a time to the motor driver. It waits out a sensor settle time, then raises color_sensor_stable. It sits between determine_state and the motor/spin driver.

---
 rtl/setup_move_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_setup_move_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/setup_move_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | setup_move_sequencer: expands a sticker index into face turns for the    |
// | motor driver, then flags the cube as settled.   Rev 1.0                  |
// +--------------------------------------------------------------------------+
module setup_move_sequencer #(
  parameter int SETTLE_CYCLES  = 1000000,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int LAST_INDEX     = 48
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_setup_moves,
  input  logic [5:0] counter,
  output logic       move_valid,
  output logic [4:0] move,
  input  logic       move_ready,
  input  logic       motor_done,
  output logic       color_sensor_stable,
  output logic       busy,
  output logic       scan_complete,
  output logic       seq_error
);

  localparam int c_cnt_max = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_settle_last  = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] c_u_cw_addr = 7'd76;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_DONE, S_SETTLE, S_STABLE
  } state_t;

  state_t               r_state;
  logic [5:0]           r_k;
  logic [1:0]           r_seg;
  logic [6:0]           r_addr;
  logic [2:0]           r_left;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_move_valid;
  logic [4:0]           r_move;
  logic                 r_stable;
  logic                 r_scan_complete;
  logic                 r_seq_error;

  // Move ROM: 0-37 setup segments, 38-75 undo segments, 76 the lone U CW.
  function automatic logic [4:0] move_rom(input logic [6:0] a);
    case (a)
      7'd0:  move_rom = 5'h0A; 7'd1:  move_rom = 5'h14;
      7'd2:  move_rom = 5'h11; 7'd3:  move_rom = 5'h0B;
      7'd4:  move_rom = 5'h12; 7'd5:  move_rom = 5'h0C;
      7'd6:  move_rom = 5'h09; 7'd7:  move_rom = 5'h13;
      7'd8:  move_rom = 5'h19; 7'd9:  move_rom = 5'h1B;
      7'd10: move_rom = 5'h0A; 7'd11: move_rom = 5'h14; 7'd12: move_rom = 5'h09;
      7'd13: move_rom = 5'h08; 7'd14: move_rom = 5'h0A; 7'd15: move_rom = 5'h14;
      7'd16: move_rom = 5'h11; 7'd17: move_rom = 5'h0B; 7'd18: move_rom = 5'h0A;
      7'd19: move_rom = 5'h10; 7'd20: move_rom = 5'h11; 7'd21: move_rom = 5'h0B;
      7'd22: move_rom = 5'h12; 7'd23: move_rom = 5'h0C; 7'd24: move_rom = 5'h0B;
      7'd25: move_rom = 5'h08; 7'd26: move_rom = 5'h12; 7'd27: move_rom = 5'h0C;
      7'd28: move_rom = 5'h09; 7'd29: move_rom = 5'h13; 7'd30: move_rom = 5'h14;
      7'd31: move_rom = 5'h08; 7'd32: move_rom = 5'h09; 7'd33: move_rom = 5'h13;
      7'd34: move_rom = 5'h1B; 7'd35: move_rom = 5'h19;
      7'd36: move_rom = 5'h1A; 7'd37: move_rom = 5'h1C;
      7'd38: move_rom = 5'h0C; 7'd39: move_rom = 5'h12;
      7'd40: move_rom = 5'h13; 7'd41: move_rom = 5'h09;
      7'd42: move_rom = 5'h14; 7'd43: move_rom = 5'h0A;
      7'd44: move_rom = 5'h0B; 7'd45: move_rom = 5'h11;
      7'd46: move_rom = 5'h19; 7'd47: move_rom = 5'h1B;
      7'd48: move_rom = 5'h0C; 7'd49: move_rom = 5'h12; 7'd50: move_rom = 5'h10;
      7'd51: move_rom = 5'h11; 7'd52: move_rom = 5'h0C; 7'd53: move_rom = 5'h12;
      7'd54: move_rom = 5'h13; 7'd55: move_rom = 5'h09; 7'd56: move_rom = 5'h08;
      7'd57: move_rom = 5'h12; 7'd58: move_rom = 5'h13; 7'd59: move_rom = 5'h09;
      7'd60: move_rom = 5'h14; 7'd61: move_rom = 5'h0A; 7'd62: move_rom = 5'h10;
      7'd63: move_rom = 5'h13; 7'd64: move_rom = 5'h14; 7'd65: move_rom = 5'h0A;
      7'd66: move_rom = 5'h0B; 7'd67: move_rom = 5'h11; 7'd68: move_rom = 5'h10;
      7'd69: move_rom = 5'h0C; 7'd70: move_rom = 5'h0B; 7'd71: move_rom = 5'h11;
      7'd72: move_rom = 5'h1C; 7'd73: move_rom = 5'h1A;
      7'd74: move_rom = 5'h19; 7'd75: move_rom = 5'h1B;
      7'd76: move_rom = 5'h08;
      default: move_rom = 5'h00;
    endcase
  endfunction

  // Returns {start[6:0], length[2:0]} for a batch's setup or undo list.
  function automatic logic [9:0] seg_rom(input logic [3:0] b, input logic undo);
    case ({undo, b})
      5'h01: seg_rom = {7'd0,  3'd2};
      5'h02: seg_rom = {7'd2,  3'd2};
      5'h03: seg_rom = {7'd4,  3'd2};
      5'h04: seg_rom = {7'd6,  3'd2};
      5'h05: seg_rom = {7'd8,  3'd2};
      5'h07: seg_rom = {7'd10, 3'd6};
      5'h08: seg_rom = {7'd16, 3'd6};
      5'h09: seg_rom = {7'd22, 3'd6};
      5'h0A: seg_rom = {7'd28, 3'd6};
      5'h0B: seg_rom = {7'd34, 3'd4};
      5'h11: seg_rom = {7'd38, 3'd2};
      5'h12: seg_rom = {7'd40, 3'd2};
      5'h13: seg_rom = {7'd42, 3'd2};
      5'h14: seg_rom = {7'd44, 3'd2};
      5'h15: seg_rom = {7'd46, 3'd2};
      5'h17: seg_rom = {7'd48, 3'd6};
      5'h18: seg_rom = {7'd54, 3'd6};
      5'h19: seg_rom = {7'd60, 3'd6};
      5'h1A: seg_rom = {7'd66, 3'd6};
      5'h1B: seg_rom = {7'd72, 3'd4};
      default: seg_rom = 10'd0;
    endcase
  endfunction

  // Step list as up to three segments: U turn, undo of batch b-1, setup of batch b.
  logic [6:0] w_start [4];
  logic [2:0] w_len   [4];
  logic [3:0] w_b;
  logic       w_aligned;
  logic [1:0] w_from;
  logic       w_have_next;
  logic [1:0] w_next_seg;

  always_comb begin
    w_b       = r_k[5:2];
    w_aligned = (r_k[1:0] == 2'd0);
    for (int i = 0; i < 4; i++) begin
      w_start[i] = 7'd0;
      w_len[i]   = 3'd0;
    end
    if (r_k != 6'd0) begin
      w_start[0] = c_u_cw_addr;
      w_len[0]   = 3'd1;
    end
    if (w_aligned && (r_k != 6'd0)) begin
      {w_start[1], w_len[1]} = seg_rom(w_b - 4'd1, 1'b1);
    end
    if (w_aligned && (r_k < 6'(LAST_INDEX))) begin
      {w_start[2], w_len[2]} = seg_rom(w_b, 1'b0);
    end
  end

  always_comb begin
    w_from      = (r_state == S_LOAD) ? 2'd0 : (r_seg + 2'd1);
    w_have_next = 1'b0;
    w_next_seg  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((i >= int'(w_from)) && (w_len[i] != 3'd0)) begin
        w_have_next = 1'b1;
        w_next_seg  = 2'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_k             <= 6'd0;
      r_seg           <= 2'd0;
      r_addr          <= 7'd0;
      r_left          <= 3'd0;
      r_cnt           <= '0;
      r_move_valid    <= 1'b0;
      r_move          <= 5'd0;
      r_stable        <= 1'b0;
      r_scan_complete <= 1'b0;
      r_seq_error     <= 1'b0;
    end else begin
      r_scan_complete <= 1'b0;
      case (r_state)
        S_IDLE, S_STABLE: begin
          if (send_setup_moves) begin
            r_k      <= counter;
            r_stable <= 1'b0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt <= '0;
          if (r_k > 6'(LAST_INDEX)) begin
            r_seq_error <= 1'b1;
            r_state     <= S_SETTLE;
          end else if (w_have_next) begin
            r_seg        <= w_next_seg;
            r_addr       <= w_start[w_next_seg];
            r_left       <= w_len[w_next_seg];
            r_move       <= move_rom(w_start[w_next_seg]);
            r_move_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end else begin
            r_state <= S_SETTLE;
          end
        end
        S_ISSUE: begin
          if (move_ready) begin
            r_move_valid <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (motor_done) begin
            r_cnt <= '0;
            if (r_left > 3'd1) begin
              r_addr       <= r_addr + 7'd1;
              r_left       <= r_left - 3'd1;
              r_move       <= move_rom(r_addr + 7'd1);
              r_move_valid <= 1'b1;
              r_state      <= S_ISSUE;
            end else if (w_have_next) begin
              r_seg        <= w_next_seg;
              r_addr       <= w_start[w_next_seg];
              r_left       <= w_len[w_next_seg];
              r_move       <= move_rom(w_start[w_next_seg]);
              r_move_valid <= 1'b1;
              r_state      <= S_ISSUE;
            end else begin
              r_state <= S_SETTLE;
            end
          end else if (r_cnt == c_timeout_last) begin
            r_seq_error <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == c_settle_last) begin
            r_stable        <= 1'b1;
            r_scan_complete <= (r_k == 6'(LAST_INDEX));
            r_state         <= S_STABLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // A request arriving mid-sequence is dropped but remembered as an error.
      if (send_setup_moves && busy) begin
        r_seq_error <= 1'b1;
      end
    end
  end

  assign busy                = (r_state == S_LOAD) || (r_state == S_ISSUE) ||
                               (r_state == S_WAIT_DONE) || (r_state == S_SETTLE);
  assign move_valid          = r_move_valid;
  assign move                = r_move;
  assign color_sensor_stable = r_stable & ~send_setup_moves;
  assign scan_complete       = r_scan_complete;
  assign seq_error           = r_seq_error;

endmodule
`default_nettype wire

// File: tb/tb_setup_move_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_setup_move_sequencer: randomized scoreboard bench with a notation-    |
// | level reference model of the setup/undo tables.   Rev 1.0                |
// +--------------------------------------------------------------------------+
module tb_setup_move_sequencer;

  localparam int SETTLE = 20;
  localparam int TMO    = 60;
  localparam int LAST   = 48;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send_setup_moves = 1'b0;
  logic [5:0] counter = 6'd0;
  logic       move_ready = 1'b0;
  logic       motor_done = 1'b0;
  logic       move_valid;
  logic [4:0] move;
  logic       color_sensor_stable;
  logic       busy;
  logic       scan_complete;
  logic       seq_error;

  setup_move_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO),
    .LAST_INDEX    (LAST)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .send_setup_moves   (send_setup_moves),
    .counter            (counter),
    .move_valid         (move_valid),
    .move               (move),
    .move_ready         (move_ready),
    .motor_done         (motor_done),
    .color_sensor_stable(color_sensor_stable),
    .busy               (busy),
    .scan_complete      (scan_complete),
    .seq_error          (seq_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];
  int hs_count = 0;
  int scan_count = 0;
  bit hold_mode = 0, force_low = 0, withhold = 0, slow_motor = 0;
  bit mon_prev_stall = 0;
  logic [4:0] mon_prev_move = 5'd0;
  logic [4:0] mon_exp;
  int rd_vcnt = 0, rd_stall = 0, motor_d = 0;

  string setup_tbl [12] = '{"", "F B'", "L' R", "F' B", "L R'", "L2 R2",
                            "", "F B' L U F B'", "L' R F U' L' R", "F' B R U F' B",
                            "L R' B' U L R'", "R2 L2 F2 B2"};
  string undo_tbl  [12] = '{"", "B F'", "R' L", "B' F", "R L'", "L2 R2",
                            "", "B F' U' L' B F'", "R' L U F' R' L", "B' F U' R' B' F",
                            "R L' U' B R L'", "B2 F2 L2 R2"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Cube notation -> {dir, face}: plain = CW (01), prime = CCW (10), 2 = half (11).
  function automatic void push_seq(input string s);
    int f;
    int d;
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      f = -1;
      case (c)
        "U": f = 0;
        "L": f = 1;
        "F": f = 2;
        "R": f = 3;
        "B": f = 4;
        "D": f = 5;
        default: f = -1;
      endcase
      if (f >= 0) begin
        d = 1;
        if (i + 1 < s.len()) begin
          if (s.getc(i + 1) == "'") begin d = 2; i++; end
          else if (s.getc(i + 1) == "2") begin d = 3; i++; end
        end
        exp_q.push_back(5'(d * 8 + f));
      end
    end
  endfunction

  function automatic void model_push(input int k);
    if (k > LAST) return;
    if (k > 0) push_seq("U");
    if ((k % 4 == 0) && (k > 0)) push_seq(undo_tbl[k / 4 - 1]);
    if ((k % 4 == 0) && (k < LAST)) push_seq(setup_tbl[k / 4]);
  endfunction

  // Monitor: scoreboard pop on each handshake, plus hold-while-stalled checks.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        mon_prev_stall = 0;
      end else begin
        if (mon_prev_stall) begin
          check("hold_valid", 32'(move_valid), 32'd1);
          check("hold_move", 32'(move), 32'(mon_prev_move));
        end
        if (move_valid && move_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_move: got %0h, expected no move", move);
          end else begin
            mon_exp = exp_q.pop_front();
            check("move_seq", 32'(move), 32'(mon_exp));
          end
        end
        mon_prev_stall = move_valid && !move_ready;
        mon_prev_move  = move;
        if (scan_complete) scan_count++;
      end
    end
  end

  // Motor driver side: ready with a per-move stall.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!move_valid) begin
        rd_vcnt = 0;
        move_ready = 1'($urandom_range(0, 1));
      end else begin
        if (rd_vcnt == 0) rd_stall = (hold_mode && hs_count == 1) ? 5 : int'($urandom_range(0, 2));
        move_ready = !force_low && (rd_vcnt >= rd_stall);
        rd_vcnt++;
      end
    end
  end

  // Motor: done pulse after each accepted move; stray pulses while a move is stalled.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && move_valid && move_ready) begin
        motor_d = slow_motor ? 4 : int'($urandom_range(0, 3));
        @(posedge clock); #1;
        repeat (motor_d) begin @(posedge clock); #1; end
        if (!withhold && reset) begin
          motor_done = 1'b1;
          @(posedge clock); #1;
          motor_done = 1'b0;
        end
      end else if (reset && move_valid && !move_ready && (rd_vcnt < rd_stall)) begin
        @(posedge clock); #1; motor_done = 1'b1;
        @(posedge clock); #1; motor_done = 1'b0;
      end
    end
  end

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    hs_count = 0;
  endtask

  task automatic timed_req(input int k, input bit exp_err);
    int n;
    bit got;
    hs_count = 0;
    scan_count = 0;
    @(posedge clock); #1;
    send_setup_moves = 1'b1;
    counter = 6'(k);
    n = 0;
    got = 0;
    while (!got && n < SETTLE + 50) begin
      @(posedge clock);
      n++;
      if (n == 1) begin #1; send_setup_moves = 1'b0; end
      @(negedge clock);
      if (color_sensor_stable) got = 1;
    end
    check("settle_latency", 32'(n), 32'(SETTLE + 2));
    check("no_moves", 32'(hs_count), 32'd0);
    check("err_after_timed", 32'(seq_error), 32'(exp_err));
  endtask

  task automatic run_req(input int k, input bit overlap);
    bit got;
    model_push(k);
    hs_count = 0;
    scan_count = 0;
    @(posedge clock); #1;
    send_setup_moves = 1'b1;
    counter = 6'(k);
    @(negedge clock);
    check("stable_gated", 32'(color_sensor_stable), 32'd0);
    @(posedge clock); #1;
    send_setup_moves = 1'b0;
    check("busy_load", 32'(busy), 32'd1);
    if (overlap) begin
      got = 0;
      for (int c = 0; c < 500 && !got; c++) begin
        @(negedge clock);
        if (hs_count >= 1 && !move_valid && busy) got = 1;
      end
      check("overlap_window", 32'(got), 32'd1);
      @(posedge clock); #1;
      send_setup_moves = 1'b1;
      counter = 6'd5;
      @(posedge clock); #1;
      send_setup_moves = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clock);
      if (color_sensor_stable) got = 1;
    end
    check("stable_rise", 32'(got), 32'd1);
    check("all_moves", 32'(exp_q.size()), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    check("scan_pulses", 32'(scan_count), (k == LAST) ? 32'd1 : 32'd0);
  endtask

  initial begin
    bit got;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", 32'(move_valid), 32'd0);
    check("rst_move", 32'(move), 32'd0);
    check("rst_stable", 32'(color_sensor_stable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_scan", 32'(scan_complete), 32'd0);
    check("rst_err", 32'(seq_error), 32'd0);
    reset = 1'b1;

    timed_req(0, 1'b0);
    run_req(1, 1'b0);
    hold_mode = 1;
    run_req(8, 1'b0);
    hold_mode = 0;
    run_req(48, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) run_req(4 * int'($urandom_range(0, 12)), 1'b0);
      else            run_req(int'($urandom_range(0, 48)), 1'b0);
    end
    check("err_clean", 32'(seq_error), 32'd0);

    slow_motor = 1;
    run_req(12, 1'b1);
    slow_motor = 0;
    check("err_overlap", 32'(seq_error), 32'd1);

    pulse_reset();
    check("err_cleared", 32'(seq_error), 32'd0);
    timed_req(50, 1'b1);

    pulse_reset();
    withhold = 1;
    model_push(1);
    @(posedge clock); #1;
    send_setup_moves = 1'b1;
    counter = 6'd1;
    @(posedge clock); #1;
    send_setup_moves = 1'b0;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clock);
      if (hs_count >= 1) got = 1;
    end
    check("tmo_handshake", 32'(got), 32'd1);
    repeat (TMO - 5) @(negedge clock);
    check("tmo_busy_before", 32'(busy), 32'd1);
    check("tmo_err_before", 32'(seq_error), 32'd0);
    got = 0;
    for (int c = 0; c < TMO + SETTLE + 50 && !got; c++) begin
      @(negedge clock);
      if (color_sensor_stable) got = 1;
    end
    check("tmo_stable", 32'(got), 32'd1);
    check("tmo_err_after", 32'(seq_error), 32'd1);
    check("tmo_moves", 32'(exp_q.size()), 32'd0);
    withhold = 0;

    force_low = 1;
    @(posedge clock); #1;
    send_setup_moves = 1'b1;
    counter = 6'd8;
    @(posedge clock); #1;
    send_setup_moves = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clock);
      if (move_valid) got = 1;
    end
    check("issue_reached", 32'(got), 32'd1);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(move_valid), 32'd0);
    check("arst_move", 32'(move), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_stable", 32'(color_sensor_stable), 32'd0);
    check("arst_scan", 32'(scan_complete), 32'd0);
    check("arst_err", 32'(seq_error), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    force_low = 0;
    exp_q.delete();
    timed_req(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
